// File: rtl/instr_fetch.sv
// Instruction fetch stage: program memory with load/warm/run sequencing and a
// registered IF/ID output (instruction, pc+4, valid, fault, fetch counter).
module instr_fetch #(
  parameter int MEM_WORDS = 64,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pc,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 prog_en,
  input  logic                 prog_we,
  input  logic [ADDR_BITS-1:0] prog_addr,
  input  logic [31:0]          prog_data,
  output logic [31:0]          instr_code,
  output logic [31:0]          pc_plus4,
  output logic                 if_valid,
  output logic                 addr_fault,
  output logic [15:0]          fetch_count
);

  typedef enum logic [1:0] {LOAD, WARM, RUN} state_t;

  state_t state, state_nxt;

  logic [31:0]          mem [MEM_WORDS];
  logic [ADDR_BITS-1:0] word_idx;
  logic                 misaligned;
  logic                 out_of_range;
  logic                 run_update;
  logic [31:0]          pc_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (!prog_en) state_nxt = WARM;
      WARM:    state_nxt = RUN;
      RUN:     if (prog_en) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // A RUN edge with prog_en already high is the edge that leaves RUN, so it
  // behaves like LOAD and forces a NOP.
  always_comb begin
    word_idx     = pc[ADDR_BITS+1:2];
    misaligned   = |pc[1:0];
    out_of_range = |pc[31:ADDR_BITS+2];
    pc_next      = pc + 32'd4;
    run_update   = (state == RUN) && !prog_en;
  end

  // Program memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (state == LOAD && prog_we) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_code  <= '0;
      pc_plus4    <= '0;
      if_valid    <= 1'b0;
      addr_fault  <= 1'b0;
      fetch_count <= '0;
    end else if (!run_update || flush) begin
      instr_code <= '0;
      if_valid   <= 1'b0;
      addr_fault <= 1'b0;
    end else if (!stall) begin
      pc_plus4 <= pc_next;
      if (misaligned || out_of_range) begin
        instr_code <= '0;
        if_valid   <= 1'b0;
        addr_fault <= 1'b1;
      end else begin
        instr_code <= mem[word_idx];
        if_valid   <= 1'b1;
        addr_fault <= 1'b0;
        if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised self-checking bench for instr_fetch against a behavioural model
// of the load/warm/run rules and the IF/ID update priorities.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        stall, flush, prog_en, prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] instr_code, pc_plus4;
  logic        if_valid, addr_fault;
  logic [15:0] fetch_count;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Model: phase 0 = loading, 1 = warm-up cycle, 2 = running
  int          m_phase;
  logic [31:0] m_mem [64];
  logic [31:0] m_instr, m_p4;
  logic        m_valid, m_fault;
  int unsigned m_count;

  instr_fetch #(.MEM_WORDS(64), .ADDR_BITS(6)) dut (
    .clk(clk), .reset(reset), .pc(pc), .stall(stall), .flush(flush),
    .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .instr_code(instr_code), .pc_plus4(pc_plus4),
    .if_valid(if_valid), .addr_fault(addr_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_fault = 0; m_count = 0;
  endtask

  // Advance the model on the current inputs, then clock the DUT and settle.
  task automatic tick();
    bit running;
    running = (m_phase == 2) && !prog_en;
    if (m_phase == 0 && prog_we) m_mem[prog_addr] = prog_data;
    if (!running || flush) begin
      m_instr = 0; m_valid = 0; m_fault = 0;
    end else if (!stall) begin
      m_p4 = pc + 32'd4;
      if ((pc % 4) != 0 || pc >= 32'd256) begin
        m_instr = 0; m_valid = 0; m_fault = 1;
      end else begin
        m_instr = m_mem[pc / 4]; m_valid = 1; m_fault = 0;
        if (m_count < 65535) m_count++;
      end
    end
    if (m_phase == 0)      m_phase = prog_en ? 0 : 1;
    else if (m_phase == 1) m_phase = 2;
    else                   m_phase = prog_en ? 0 : 2;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc = 0; stall = 0; flush = 0;
    prog_en = 1; prog_we = 0; prog_addr = 0; prog_data = 0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    model_reset();
    total++; if (instr_code !== 32'h0) $display("FAIL reset_instr got %h want 0", instr_code); else passed++;
    total++; if (pc_plus4 !== 32'h0) $display("FAIL reset_pc4 got %h want 0", pc_plus4); else passed++;
    total++; if ({if_valid, addr_fault} !== 2'b00) $display("FAIL reset_flags got %b want 00", {if_valid, addr_fault}); else passed++;
    total++; if (fetch_count !== 16'h0) $display("FAIL reset_count got %h want 0", fetch_count); else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load();
    logic [31:0] prog [4];
    prog[0] = 32'h20080005; prog[1] = 32'h20090003;
    prog[2] = 32'h01095020; prog[3] = 32'h08000000;
    prog_en = 1;
    for (int i = 0; i < 64; i++) begin
      prog_we = 1; prog_addr = 6'(i);
      prog_data = (i < 4) ? prog[i] : $urandom;
      tick();
    end
    prog_we = 0; prog_en = 0;
    tick();
    total++; if (if_valid !== 1'b0) $display("FAIL load_exit_valid got %b want 0", if_valid); else passed++;
    tick();
    total++; if (if_valid !== 1'b0) $display("FAIL warm_valid got %b want 0", if_valid); else passed++;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4);
      tick();
      total++; if (instr_code !== m_instr) $display("FAIL seq_instr%0d got %h want %h", i, instr_code, m_instr); else passed++;
      total++; if (pc_plus4 !== 32'(i * 4 + 4)) $display("FAIL seq_pc4_%0d got %h want %h", i, pc_plus4, i * 4 + 4); else passed++;
      total++; if (if_valid !== 1'b1) $display("FAIL seq_valid%0d got %b want 1", i, if_valid); else passed++;
    end
    total++; if (fetch_count !== 16'd4) $display("FAIL seq_count got %0d want 4", fetch_count); else passed++;
  endtask

  task automatic test_stall_flush();
    logic [15:0] cnt_before;
    pc = 8; tick();
    cnt_before = fetch_count;
    stall = 1; pc = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (instr_code !== 32'h01095020) $display("FAIL stall_instr%0d got %h want 01095020", i, instr_code); else passed++;
      total++; if (fetch_count !== cnt_before) $display("FAIL stall_count%0d got %0d want %0d", i, fetch_count, cnt_before); else passed++;
    end
    flush = 1; tick();
    total++; if ({instr_code, if_valid} !== 33'h0) $display("FAIL flush_nop got %h/%b want 0/0", instr_code, if_valid); else passed++;
    total++; if (fetch_count !== cnt_before) $display("FAIL flush_count got %0d want %0d", fetch_count, cnt_before); else passed++;
    total++; if (pc_plus4 !== 32'd12) $display("FAIL flush_pc4 got %h want c", pc_plus4); else passed++;
    stall = 0; flush = 0;
  endtask

  task automatic test_faults();
    pc = 32'h6; tick();
    total++; if ({addr_fault, if_valid} !== 2'b10 || instr_code !== 0) $display("FAIL fault_misalign got %b%b/%h want 10/0", addr_fault, if_valid, instr_code); else passed++;
    pc = 32'h100; tick();
    total++; if (addr_fault !== 1'b1) $display("FAIL fault_range got %b want 1", addr_fault); else passed++;
    total++; if (pc_plus4 !== 32'h104) $display("FAIL fault_pc4 got %h want 104", pc_plus4); else passed++;
    pc = 32'h0; tick();
    total++; if ({addr_fault, if_valid} !== 2'b01 || instr_code !== 32'h20080005) $display("FAIL fault_clear got %b%b/%h want 01/20080005", addr_fault, if_valid, instr_code); else passed++;
  endtask

  task automatic test_guard();
    prog_we = 1; prog_addr = 0; prog_data = 32'hFFFFFFFF; pc = 4;
    tick(); tick();
    prog_we = 0; pc = 0; tick();
    total++; if (instr_code !== 32'h20080005) $display("FAIL guard got %h want 20080005", instr_code); else passed++;
  endtask

  task automatic test_wrap();
    pc = 32'hFFFFFFFC; tick();
    total++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_pc4 got %h want 0", pc_plus4); else passed++;
    total++; if (addr_fault !== 1'b1) $display("FAIL wrap_fault got %b want 1", addr_fault); else passed++;
  endtask

  task automatic test_prog_en_run();
    pc = 4; prog_en = 1; tick();
    total++; if ({if_valid, instr_code} !== 33'h0) $display("FAIL progen_nop got %b/%h want 0/0", if_valid, instr_code); else passed++;
    prog_en = 0; tick(); tick();
    pc = 12; tick();
    total++; if (instr_code !== 32'h08000000) $display("FAIL progen_resume got %h want 08000000", instr_code); else passed++;
  endtask

  task automatic test_random();
    int unsigned errs = 0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       pc = $urandom;
        1:       pc = 32'($urandom_range(0, 255));
        default: pc = 32'($urandom_range(0, 63) * 4);
      endcase
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      tick();
      if ({instr_code, pc_plus4, if_valid, addr_fault, fetch_count} !==
          {m_instr, m_p4, m_valid, m_fault, 16'(m_count)}) begin
        errs++;
        if (errs <= 5)
          $display("FAIL rand%0d got %h %h %b%b %0d want %h %h %b%b %0d", i, instr_code, pc_plus4,
                   if_valid, addr_fault, fetch_count, m_instr, m_p4, m_valid, m_fault, m_count);
      end
    end
    total++; if (errs != 0) $display("FAIL rand_total got %0d mismatching cycles want 0", errs); else passed++;
    stall = 0; flush = 0;
  endtask

  task automatic test_mid_reset();
    pc = 8; tick();
    #3 reset = 1'b0;
    #1;
    model_reset();
    total++; if ({instr_code, pc_plus4, if_valid, addr_fault, fetch_count} !== 82'h0)
      $display("FAIL midreset got %h %h %b%b %0d want all 0", instr_code, pc_plus4, if_valid, addr_fault, fetch_count);
    else passed++;
    @(negedge clk);
    reset = 1'b1; prog_en = 0;
    tick(); tick();
    pc = 4; tick();
    total++; if (instr_code !== 32'h20090003) $display("FAIL mem_kept got %h want 20090003", instr_code); else passed++;
  endtask

  task automatic test_saturate();
    pc = 0;
    for (int i = 0; i < 65540; i++) tick();
    total++; if (fetch_count !== 16'hFFFF) $display("FAIL sat_count got %h want ffff", fetch_count); else passed++;
    total++; if (m_count != 65535) $display("FAIL sat_model got %0d want 65535", m_count); else passed++;
    pc = 4; tick();
    total++; if (fetch_count !== 16'hFFFF || instr_code !== 32'h20090003) $display("FAIL sat_hold got %h/%h want ffff/20090003", fetch_count, instr_code); else passed++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_sequential();
    test_stall_flush();
    test_faults();
    test_guard();
    test_wrap();
    test_prog_en_run();
    test_random();
    test_mid_reset();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
